// File: rtl/mult_sched.sv
// mult_sched: round-robin issue arbiter plus shadow tracker for one shared pipelined multiplier.
// The shadow pipeline mirrors the multiplier to drive stall, CDB broadcast, squash and error detection.
`timescale 1ns/1ps
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

module mult_sched #(
  parameter int NUM_REQ = 4,
  parameter int STAGES  = `MULT_STAGES,
  parameter int TAG_W   = 6,
  localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     mult_start,
  output logic [SEL_W-1:0]         mult_sel,
  output logic                     mult_stall,
  input  logic                     mult_done,
  output logic                     cdb_req,
  input  logic                     cdb_gnt,
  output logic [TAG_W-1:0]         cdb_tag,
  input  logic                     flush,
  output logic [CNT_W-1:0]         inflight,
  output logic                     busy,
  output logic                     err
);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ghost_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [SEL_W-1:0]  ptr_q;

  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] ghost_d;
  logic [SEL_W:0]    pick;
  logic [SEL_W-1:0]  gnt_sel;
  logic [SEL_W-1:0]  next_ptr;
  logic [TAG_W-1:0]  new_tag;
  logic              arb_en;
  logic              grant;
  logic              advance;
  logic              exp_done;

  // Returns {found, index} of the first asserted request at or after p, wrapping.
  // Scanning from the far end lets the nearest hit overwrite earlier ones without a break.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [SEL_W-1:0]   p);
    logic [SEL_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (r[idx]) res = {1'b1, idx[SEL_W-1:0]};
    end
    return res;
  endfunction

  // Tail control: only a live result can hold the pipeline or ask for the CDB.
  assign mult_stall = vld_q[STAGES-1] & ~cdb_gnt;
  assign advance    = ~mult_stall;
  assign cdb_req    = vld_q[STAGES-1];
  assign cdb_tag    = tag_q[STAGES-1];
  assign exp_done   = vld_q[STAGES-1] | ghost_q[STAGES-1];

  // Arbitration is suppressed in reset so gnt reads 0 without waiting for a clock.
  assign arb_en     = reset & ~mult_stall & ~flush;
  assign pick       = rr_pick(req, ptr_q);
  assign grant      = arb_en & pick[SEL_W];
  assign gnt_sel    = pick[SEL_W-1:0];
  assign mult_start = grant;
  assign mult_sel   = grant ? gnt_sel : '0;
  assign next_ptr   = (gnt_sel == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_sel + 1'b1;

  always_comb begin
    gnt = '0;
    if (grant) gnt[gnt_sel] = 1'b1;
  end

  always_comb begin
    new_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_sel == SEL_W'(i)) new_tag = req_tag[i*TAG_W +: TAG_W];
    end
  end

  // Next shadow state: shift on advance, then a flush turns every live entry into a ghost.
  always_comb begin
    vld_d   = vld_q;
    ghost_d = ghost_q;
    if (advance) begin
      vld_d[0]   = grant;
      ghost_d[0] = 1'b0;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]   = vld_q[i-1];
        ghost_d[i] = ghost_q[i-1];
      end
    end
    if (flush) begin
      ghost_d = ghost_d | vld_d;
      vld_d   = '0;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + CNT_W'(vld_q[i]);
  end

  assign busy = (|vld_q) | (|ghost_q);

  // Stage register boundary: shadow pipeline, arbitration pointer, sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      ghost_q <= '0;
      ptr_q   <= '0;
      err     <= 1'b0;
      for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      ghost_q <= ghost_d;
      err     <= err | (mult_done ^ exp_done);
      if (grant) ptr_q <= next_ptr;
      if (advance) begin
        tag_q[0] <= new_tag;
        for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Testbench for mult_sched: directed scenarios plus randomized traffic against an operation-list model.
`timescale 1ns/1ps

module tb_mult_sched;
  localparam int NUM_REQ = 4;
  localparam int STAGES  = 4;
  localparam int TAG_W   = 6;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] req_tag;
  logic [3:0]  gnt;
  logic        mult_start;
  logic [1:0]  mult_sel;
  logic        mult_stall;
  logic        mult_done;
  logic        cdb_req;
  logic        cdb_gnt;
  logic [5:0]  cdb_tag;
  logic        flush;
  logic [2:0]  inflight;
  logic        busy;
  logic        err;

  int checks = 0;
  int passes = 0;

  mult_sched #(.NUM_REQ(NUM_REQ), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .req(req), .req_tag(req_tag), .gnt(gnt),
    .mult_start(mult_start), .mult_sel(mult_sel), .mult_stall(mult_stall),
    .mult_done(mult_done), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag),
    .flush(flush), .inflight(inflight), .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  // Reference model: a list of issued operations, each with its age in the pipe.
  typedef struct {
    int tag;
    bit ghost;
    int pos;
  } op_t;

  op_t ops[$];
  int  m_ptr = 0;
  bit  m_err = 1'b0;

  function automatic bit m_tail_live();
    foreach (ops[i]) if (ops[i].pos == STAGES - 1 && !ops[i].ghost) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_tail_any();
    foreach (ops[i]) if (ops[i].pos == STAGES - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_tail_tag();
    foreach (ops[i]) if (ops[i].pos == STAGES - 1) return ops[i].tag;
    return 0;
  endfunction

  function automatic int m_live();
    int n;
    n = 0;
    foreach (ops[i]) if (!ops[i].ghost) n++;
    return n;
  endfunction

  function automatic bit m_stall();
    return m_tail_live() && !cdb_gnt;
  endfunction

  function automatic int m_gnt_idx();
    int idx;
    if (!reset || m_stall() || flush || req == 4'b0) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_update();
    int g;
    bit st;
    op_t n;
    if (!reset) begin
      ops.delete();
      m_ptr = 0;
      m_err = 1'b0;
      return;
    end
    g  = m_gnt_idx();
    st = m_stall();
    if (mult_done != m_tail_any()) m_err = 1'b1;
    if (flush) foreach (ops[i]) ops[i].ghost = 1'b1;
    if (!st) begin
      foreach (ops[i]) ops[i].pos++;
      while (ops.size() > 0 && ops[0].pos >= STAGES) void'(ops.pop_front());
      if (g >= 0) begin
        n.tag   = int'(req_tag[g*TAG_W +: TAG_W]);
        n.ghost = 1'b0;
        n.pos   = 0;
        ops.push_back(n);
      end
    end
    if (g >= 0) m_ptr = (g + 1) % NUM_REQ;
  endtask

  // One clock: update the model at the edge, then play a well-behaved multiplier.
  task automatic tick();
    @(posedge clock);
    m_update();
    #1;
    mult_done = m_tail_any();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    req_tag   = '0;
    flush     = 1'b0;
    cdb_gnt   = 1'b1;
    mult_done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    req   = '0;
    flush = 1'b0;
    cdb_gnt = 1'b1;
    for (int c = 0; c < STAGES + 2; c++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; req_tag = 24'hFFFFFF; flush = 1'b0; cdb_gnt = 1'b0; mult_done = 1'b0;
    #3;
    for (int r = 0; r < 2; r++) begin
      checks++; if (gnt !== 4'b0) $display("FAIL reset_gnt got %b want 0000", gnt); else passes++;
      checks++; if (mult_start !== 1'b0) $display("FAIL reset_start got %b want 0", mult_start); else passes++;
      checks++; if (mult_sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", mult_sel); else passes++;
      checks++; if (mult_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", mult_stall); else passes++;
      checks++; if (cdb_req !== 1'b0 || cdb_tag !== 6'd0) $display("FAIL reset_cdb got %b/%h want 0/00", cdb_req, cdb_tag); else passes++;
      checks++; if (inflight !== 3'd0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_status got %0d/%b/%b want 0/0/0", inflight, busy, err); else passes++;
      tick();
      #1;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; req_tag = '0; req_tag[2*TAG_W +: TAG_W] = 6'h15; cdb_gnt = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0100) $display("FAIL single_gnt got %b want 0100", gnt); else passes++;
    checks++; if (mult_sel !== 2'd2) $display("FAIL single_sel got %0d want 2", mult_sel); else passes++;
    checks++; if (mult_start !== 1'b1) $display("FAIL single_start got %b want 1", mult_start); else passes++;
    tick();
    req = '0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++; if (cdb_req !== (c == 4)) $display("FAIL single_cdb_req c%0d got %b want %b", c, cdb_req, (c == 4)); else passes++;
      if (c == 4) begin
        checks++; if (cdb_tag !== 6'h15) $display("FAIL single_cdb_tag got %h want 15", cdb_tag); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rr [6];
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    req_tag = {6'h13, 6'h12, 6'h11, 6'h10};
    for (int c = 0; c < 6; c++) begin
      req = 4'b1111;
      #1;
      checks++; if (gnt !== exp_rr[c]) $display("FAIL rr_gnt c%0d got %b want %b", c, gnt, exp_rr[c]); else passes++;
      if (c == 4) begin
        checks++; if (inflight !== 3'd4) $display("FAIL rr_inflight got %0d want 4", inflight); else passes++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_stall();
    do_reset();
    req_tag = {6'h13, 6'h12, 6'h11, 6'h10};
    req = 4'b1111;
    for (int c = 0; c < 4; c++) tick();
    cdb_gnt = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      #1;
      checks++; if (mult_stall !== 1'b1) $display("FAIL stall_stall c%0d got %b want 1", c, mult_stall); else passes++;
      checks++; if (gnt !== 4'b0) $display("FAIL stall_gnt c%0d got %b want 0000", c, gnt); else passes++;
      checks++; if (inflight !== 3'd4) $display("FAIL stall_inflight c%0d got %0d want 4", c, inflight); else passes++;
      checks++; if (cdb_tag !== 6'h10) $display("FAIL stall_tag c%0d got %h want 10", c, cdb_tag); else passes++;
      tick();
    end
    cdb_gnt = 1'b1;
    #1;
    checks++; if (mult_stall !== 1'b0) $display("FAIL stall_release got %b want 0", mult_stall); else passes++;
    checks++; if (gnt !== 4'b0001) $display("FAIL stall_resume_gnt got %b want 0001", gnt); else passes++;
    tick();
    req = '0;
    #1;
    checks++; if (cdb_req !== 1'b1 || cdb_tag !== 6'h11) $display("FAIL stall_drain got %b/%h want 1/11", cdb_req, cdb_tag); else passes++;
    tick();
    // Flush while the tail is stalled: the result is dropped and the stall releases.
    cdb_gnt = 1'b0; flush = 1'b1;
    #1;
    checks++; if (mult_stall !== 1'b1) $display("FAIL flushstall_pre got %b want 1", mult_stall); else passes++;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (mult_stall !== 1'b0 || cdb_req !== 1'b0) $display("FAIL flushstall_post got %b/%b want 0/0", mult_stall, cdb_req); else passes++;
    checks++; if (inflight !== 3'd0 || busy !== 1'b1) $display("FAIL flushstall_status got %0d/%b want 0/1", inflight, busy); else passes++;
    drain();
    #1;
    checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL flushstall_end got %b/%b want 0/0", busy, err); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    req_tag = {6'h23, 6'h22, 6'h21, 6'h20};
    req = 4'b0001;
    tick();
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) $display("FAIL flush_gnt1 got %b want 0010", gnt); else passes++;
    tick();
    req = 4'b1111; flush = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0) $display("FAIL flush_gnt_block got %b want 0000", gnt); else passes++;
    checks++; if (inflight !== 3'd2) $display("FAIL flush_pre_inflight got %0d want 2", inflight); else passes++;
    tick();
    flush = 1'b0; req = '0;
    for (int c = 3; c <= 6; c++) begin
      #1;
      checks++; if (cdb_req !== 1'b0) $display("FAIL flush_cdb c%0d got %b want 0", c, cdb_req); else passes++;
      checks++; if (busy !== (c <= 5)) $display("FAIL flush_busy c%0d got %b want %b", c, busy, (c <= 5)); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL flush_err c%0d got %b want 0", c, err); else passes++;
      if (c == 3) begin
        checks++; if (inflight !== 3'd0) $display("FAIL flush_inflight got %0d want 0", inflight); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_err();
    do_reset();
    for (int c = 0; c < 3; c++) tick();
    mult_done = 1'b1;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL err_before got %b want 0", err); else passes++;
    tick();
    for (int c = 4; c <= 6; c++) begin
      #1;
      checks++; if (err !== 1'b1) $display("FAIL err_sticky c%0d got %b want 1", c, err); else passes++;
      tick();
    end
    reset = 1'b0;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL err_reset got %b want 0", err); else passes++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_tag = {6'h33, 6'h32, 6'h31, 6'h30};
    req = 4'b1111;
    for (int c = 0; c < 3; c++) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0 || mult_start !== 1'b0 || mult_sel !== 2'd0) $display("FAIL midrst_arb got %b/%b/%0d want 0000/0/0", gnt, mult_start, mult_sel); else passes++;
    checks++; if (mult_stall !== 1'b0 || cdb_req !== 1'b0 || cdb_tag !== 6'd0) $display("FAIL midrst_tail got %b/%b/%h want 0/0/00", mult_stall, cdb_req, cdb_tag); else passes++;
    checks++; if (inflight !== 3'd0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL midrst_status got %0d/%b/%b want 0/0/0", inflight, busy, err); else passes++;
    tick();
    tick();
    reset = 1'b1; req = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (cdb_req !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_after c%0d got %b/%b want 0/0", c, cdb_req, busy); else passes++;
      tick();
    end
    req = 4'b1010;
    #1;
    checks++; if (gnt !== 4'b0010) $display("FAIL midrst_first_gnt got %b want 0010", gnt); else passes++;
    tick();
    drain();
  endtask

  task automatic test_random();
    int g;
    logic [3:0] exp_gnt;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      req     = 4'($urandom);
      req_tag = 24'($urandom);
      cdb_gnt = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      #1;
      g = m_gnt_idx();
      exp_gnt = (g >= 0) ? 4'(1 << g) : 4'b0;
      checks++; if (gnt !== exp_gnt) $display("FAIL rand_gnt n%0d got %b want %b", n, gnt, exp_gnt); else passes++;
      checks++; if (mult_sel !== 2'((g >= 0) ? g : 0) || mult_start !== (g >= 0)) $display("FAIL rand_sel n%0d got %0d/%b want %0d/%b", n, mult_sel, mult_start, (g >= 0) ? g : 0, (g >= 0)); else passes++;
      checks++; if (mult_stall !== m_stall()) $display("FAIL rand_stall n%0d got %b want %b", n, mult_stall, m_stall()); else passes++;
      checks++; if (cdb_req !== m_tail_live()) $display("FAIL rand_cdb_req n%0d got %b want %b", n, cdb_req, m_tail_live()); else passes++;
      if (m_tail_live()) begin
        checks++; if (cdb_tag !== 6'(m_tail_tag())) $display("FAIL rand_cdb_tag n%0d got %h want %h", n, cdb_tag, 6'(m_tail_tag())); else passes++;
      end
      checks++; if (inflight !== 3'(m_live())) $display("FAIL rand_inflight n%0d got %0d want %0d", n, inflight, m_live()); else passes++;
      checks++; if (busy !== (ops.size() != 0)) $display("FAIL rand_busy n%0d got %b want %b", n, busy, (ops.size() != 0)); else passes++;
      checks++; if (err !== m_err) $display("FAIL rand_err n%0d got %b want %b", n, err, m_err); else passes++;
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_flush();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of issue requesters sharing one pipelined multiplier.
REQ-002 Parameter STAGES, default `MULT_STAGES (4): multiplier pipeline depth, in cycles.
REQ-003 Parameter TAG_W, default 6: physical destination tag width.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset; asserting it (0) clears state immediately, independent of clock.
REQ-006 req  in  NUM_REQ  per-requester issue request, level-sensitive.
REQ-007 req_tag  in  NUM_REQ*TAG_W  destination tag per requester; slice i belongs to req[i].
REQ-008 gnt  out  NUM_REQ  one-hot grant; the granted requester's operands are accepted this cycle.
REQ-009 mult_start  out  1  drives the multiplier rd_in; equals |gnt.
REQ-010 mult_sel  out  $clog2(NUM_REQ)  index of the granted requester, for the operand mux; 0 when gnt=0.
REQ-011 mult_stall  out  1  drives the multiplier stall input.
REQ-012 mult_done  in  1  multiplier data_ready.
REQ-013 cdb_req  out  1  result broadcast request.
REQ-014 cdb_gnt  in  1  CDB accepts the result this cycle.
REQ-015 cdb_tag  out  TAG_W  tag of the result at the pipeline tail.
REQ-016 flush  in  1  squash all in-flight operations (branch mispredict).
REQ-017 inflight  out  $clog2(STAGES+1)  count of live (non-squashed) operations.
REQ-018 busy  out  1  any live or squashed operation still in the pipeline.
REQ-019 err  out  1  sticky tracking-mismatch flag.

Function
REQ-020 Shadow pipeline: the block SHALL hold vld[STAGES], ghost[STAGES] and tag[STAGES]; stage 0 is the entry and stage STAGES-1 is the tail.
REQ-021 The shadow pipeline SHALL advance only in cycles where mult_stall=0, in lockstep with the multiplier.
REQ-022 mult_stall SHALL equal vld[STAGES-1] & ~cdb_gnt, combinationally.
REQ-023 cdb_req SHALL equal vld[STAGES-1], and cdb_tag SHALL equal tag[STAGES-1].
REQ-024 A ghost at the tail SHALL never stall the pipeline and SHALL never request the CDB.
REQ-025 Arbitration SHALL be round-robin with pointer ptr: gnt selects the first asserted req index at or after ptr, wrapping modulo NUM_REQ.
REQ-026 On any grant, ptr SHALL become (granted index + 1) mod NUM_REQ.
REQ-027 gnt SHALL be 0 when mult_stall=1, when flush=1, or when req=0; ptr SHALL hold in those cycles.
REQ-028 On an advancing cycle, stage 0 SHALL load vld=|gnt, ghost=0, and tag=req_tag of the granted requester.
REQ-029 Latency: a grant in cycle t with no stalls SHALL give cdb_req=1 in cycle t+STAGES; each stall cycle adds exactly one cycle.
REQ-030 On flush=1, on the next edge every vld bit SHALL move to the corresponding ghost bit, shifted if advancing, and all vld SHALL clear; tag contents are don't-care.
REQ-031 Flush together with mult_stall=1 SHALL still squash; the tail result SHALL be dropped and the pipeline released on the next cycle.
REQ-032 Expected done SHALL be vld[STAGES-1] | ghost[STAGES-1]; err SHALL set when mult_done differs from expected done and SHALL remain set until reset.
REQ-033 inflight SHALL equal popcount(vld); busy SHALL equal |vld | |ghost.

Reset
REQ-034 While reset=0, the block SHALL clear vld, ghost, tag, ptr and err to 0.
REQ-035 While reset=0, outputs SHALL read gnt=0, mult_start=0, mult_sel=0, mult_stall=0, cdb_req=0, cdb_tag=0, inflight=0, busy=0, err=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight operations with no cdb_req afterwards; the first grant after release SHALL go to the lowest asserted index.

Verification (NUM_REQ=4, STAGES=4, cycle 0 = first edge after reset release)
REQ-037 req=0100, tag2=0x15 at cycle 0, cdb_gnt=1 -> gnt=0100, mult_sel=2, mult_start=1 in cycle 0; cdb_req=1 with cdb_tag=0x15 in cycle 4 only.
REQ-038 req=1111 held cycles 0-5 -> gnt sequence 0001,0010,0100,1000,0001,0010; inflight reaches 4 at cycle 4.
REQ-039 Full pipeline, cdb_gnt=0 in cycles 4-6 -> mult_stall=1 and gnt=0 in cycles 4-6; inflight stays 4; cdb_tag stable; draining resumes in cycle 7.
REQ-040 Grants in cycles 0 and 1, flush in cycle 2 -> inflight=0 in cycle 3, busy=1 until the ghosts exit; mult_done pulses in cycles 4-5 raise no cdb_req and leave err=0.
REQ-041 mult_done forced high in cycle 3 with an empty pipeline -> err=1 from cycle 4, held until reset.
REQ-042 reset driven low mid-cycle with 3 in flight -> all outputs 0 immediately without a clock edge; no cdb_req after release.
